// File: rtl/alu_rs_scheduler.sv
// Reservation-station scheduler: buffers dispatched ALU ops, wakes operands off the CDB,
// and issues the lowest-index ready op into a registered ALU input stage each cycle.
module alu_rs_scheduler #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 4,
    parameter int OP_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             disp_valid,
    input  logic [OP_W-1:0]  disp_op,
    input  logic [31:0]      disp_v1,
    input  logic [31:0]      disp_v2,
    input  logic             disp_rdy1,
    input  logic             disp_rdy2,
    input  logic [TAG_W-1:0] disp_q1,
    input  logic [TAG_W-1:0] disp_q2,
    input  logic [31:0]      disp_imm,
    input  logic [31:0]      disp_pc,
    input  logic [TAG_W-1:0] disp_tag,
    output logic             full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic [OP_W-1:0]  alu_op,
    output logic [31:0]      alu_v1,
    output logic [31:0]      alu_v2,
    output logic [31:0]      alu_imm,
    output logic [31:0]      alu_pc,
    output logic             alu_empty,
    output logic [TAG_W-1:0] alu_tag
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] busy, rdy1, rdy2;
    logic [OP_W-1:0]  e_op  [DEPTH];
    logic [31:0]      e_v1  [DEPTH];
    logic [31:0]      e_v2  [DEPTH];
    logic [31:0]      e_imm [DEPTH];
    logic [31:0]      e_pc  [DEPTH];
    logic [TAG_W-1:0] e_q1  [DEPTH];
    logic [TAG_W-1:0] e_q2  [DEPTH];
    logic [TAG_W-1:0] e_tag [DEPTH];

    logic [IDX_W-1:0] free_idx, iss_idx;
    logic             iss_valid, disp_accept, byp1, byp2;

    // Descending scan so the last hit is the lowest index.
    always_comb begin
        free_idx  = '0;
        iss_idx   = '0;
        iss_valid = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = IDX_W'(i);
            if (busy[i] && rdy1[i] && rdy2[i]) begin
                iss_valid = 1'b1;
                iss_idx   = IDX_W'(i);
            end
        end
    end

    assign full        = &busy;
    assign disp_accept = disp_valid && !full && !flush;
    assign byp1        = !disp_rdy1 && cdb_valid && (cdb_tag == disp_q1);
    assign byp2        = !disp_rdy2 && cdb_valid && (cdb_tag == disp_q2);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy      <= '0;
            alu_empty <= 1'b1;
            alu_op    <= '0;
            alu_v1    <= '0;
            alu_v2    <= '0;
            alu_imm   <= '0;
            alu_pc    <= '0;
            alu_tag   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && cdb_valid && !rdy1[i] && (e_q1[i] == cdb_tag)) begin
                    e_v1[i] <= cdb_data;
                    rdy1[i] <= 1'b1;
                end
                if (busy[i] && cdb_valid && !rdy2[i] && (e_q2[i] == cdb_tag)) begin
                    e_v2[i] <= cdb_data;
                    rdy2[i] <= 1'b1;
                end
            end

            // Selection used pre-wakeup state, so a CDB hit issues no earlier than next edge.
            if (iss_valid) begin
                alu_empty     <= 1'b0;
                alu_op        <= e_op[iss_idx];
                alu_v1        <= e_v1[iss_idx];
                alu_v2        <= e_v2[iss_idx];
                alu_imm       <= e_imm[iss_idx];
                alu_pc        <= e_pc[iss_idx];
                alu_tag       <= e_tag[iss_idx];
                busy[iss_idx] <= 1'b0;
            end else begin
                alu_empty <= 1'b1;
                alu_op    <= '0;
                alu_v1    <= '0;
                alu_v2    <= '0;
                alu_imm   <= '0;
                alu_pc    <= '0;
                alu_tag   <= '0;
            end

            // free_idx is never the issuing slot: that one is busy in the pre-edge state.
            if (disp_accept) begin
                busy[free_idx]  <= 1'b1;
                e_op[free_idx]  <= disp_op;
                e_v1[free_idx]  <= byp1 ? cdb_data : disp_v1;
                e_v2[free_idx]  <= byp2 ? cdb_data : disp_v2;
                rdy1[free_idx]  <= disp_rdy1 || byp1;
                rdy2[free_idx]  <= disp_rdy2 || byp2;
                e_q1[free_idx]  <= disp_q1;
                e_q2[free_idx]  <= disp_q2;
                e_imm[free_idx] <= disp_imm;
                e_pc[free_idx]  <= disp_pc;
                e_tag[free_idx] <= disp_tag;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Bench for alu_rs_scheduler: directed vector table, hand-written corner sequences,
// and a randomized run against a behavioural slot model.
module tb_alu_rs_scheduler;

    logic        clk = 1'b0;
    logic        rst, flush, disp_valid, disp_rdy1, disp_rdy2, cdb_valid;
    logic [5:0]  disp_op;
    logic [31:0] disp_v1, disp_v2, disp_imm, disp_pc, cdb_data;
    logic [3:0]  disp_q1, disp_q2, disp_tag, cdb_tag;
    logic        full, alu_empty;
    logic [5:0]  alu_op;
    logic [31:0] alu_v1, alu_v2, alu_imm, alu_pc;
    logic [3:0]  alu_tag;

    alu_rs_scheduler #(.DEPTH(8), .TAG_W(4), .OP_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_v1(disp_v1), .disp_v2(disp_v2),
        .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2), .disp_q1(disp_q1), .disp_q2(disp_q2),
        .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_tag(disp_tag), .full(full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .alu_op(alu_op), .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_imm(alu_imm), .alu_pc(alu_pc),
        .alu_empty(alu_empty), .alu_tag(alu_tag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_model = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a pool of slots plus the value the ALU stage should present.
    typedef struct {
        bit          busy;
        logic [5:0]  op;
        logic [31:0] v1, v2, imm, pc;
        bit          r1, r2;
        logic [3:0]  q1, q2, tag;
    } ent_t;

    ent_t        m[8];
    bit          m_empty = 1'b1;
    logic [5:0]  m_op  = '0;
    logic [31:0] m_v1  = '0, m_v2 = '0, m_imm = '0, m_pc = '0;
    logic [3:0]  m_tag = '0;

    function automatic bit m_full();
        for (int i = 0; i < 8; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        int iss = -1;
        int fr  = -1;
        bit was_full = m_full();
        if (rst || flush) begin
            for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
            m_empty = 1'b1; m_op = '0; m_v1 = '0; m_v2 = '0; m_imm = '0; m_pc = '0; m_tag = '0;
            return;
        end
        for (int i = 0; i < 8; i++) begin
            if (fr < 0 && !m[i].busy) fr = i;
            if (iss < 0 && m[i].busy && m[i].r1 && m[i].r2) iss = i;
        end
        if (iss >= 0) begin
            m_empty = 1'b0; m_op = m[iss].op; m_v1 = m[iss].v1; m_v2 = m[iss].v2;
            m_imm = m[iss].imm; m_pc = m[iss].pc; m_tag = m[iss].tag;
        end else begin
            m_empty = 1'b1; m_op = '0; m_v1 = '0; m_v2 = '0; m_imm = '0; m_pc = '0; m_tag = '0;
        end
        if (cdb_valid) begin
            for (int i = 0; i < 8; i++) begin
                if (m[i].busy && !m[i].r1 && m[i].q1 == cdb_tag) begin m[i].r1 = 1'b1; m[i].v1 = cdb_data; end
                if (m[i].busy && !m[i].r2 && m[i].q2 == cdb_tag) begin m[i].r2 = 1'b1; m[i].v2 = cdb_data; end
            end
        end
        if (iss >= 0) m[iss].busy = 1'b0;
        if (disp_valid && !was_full) begin
            m[fr].busy = 1'b1; m[fr].op = disp_op; m[fr].imm = disp_imm; m[fr].pc = disp_pc;
            m[fr].tag = disp_tag; m[fr].q1 = disp_q1; m[fr].q2 = disp_q2;
            m[fr].r1 = disp_rdy1; m[fr].v1 = disp_v1;
            m[fr].r2 = disp_rdy2; m[fr].v2 = disp_v2;
            if (!disp_rdy1 && cdb_valid && cdb_tag == disp_q1) begin m[fr].r1 = 1'b1; m[fr].v1 = cdb_data; end
            if (!disp_rdy2 && cdb_valid && cdb_tag == disp_q2) begin m[fr].r2 = 1'b1; m[fr].v2 = cdb_data; end
        end
    endtask

    task automatic cycle();
        if (chk_model) chk("model_full", full, m_full());
        @(posedge clk);
        model_step();
        #1;
        if (chk_model) begin
            chk("model_empty", alu_empty, m_empty);
            chk("model_op", alu_op, m_op);
            chk("model_v1", alu_v1, m_v1);
            chk("model_v2", alu_v2, m_v2);
            chk("model_imm", alu_imm, m_imm);
            chk("model_pc", alu_pc, m_pc);
            chk("model_tag", alu_tag, m_tag);
        end
    endtask

    task automatic set_idle();
        rst = 0; flush = 0; disp_valid = 0; disp_op = '0; disp_v1 = '0; disp_v2 = '0;
        disp_rdy1 = 0; disp_rdy2 = 0; disp_q1 = '0; disp_q2 = '0; disp_imm = '0; disp_pc = '0;
        disp_tag = '0; cdb_valid = 0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic set_disp(input logic [5:0] op, input logic [31:0] v1, v2,
                            input bit r1, r2, input logic [3:0] q1, tag);
        disp_valid = 1; disp_op = op; disp_v1 = v1; disp_v2 = v2;
        disp_rdy1 = r1; disp_rdy2 = r2; disp_q1 = q1; disp_q2 = '0; disp_tag = tag;
    endtask

    // One row = inputs for a cycle and the ALU stage expected after that cycle's edge.
    typedef struct {
        bit          rst, dv;
        logic [5:0]  op;
        logic [31:0] v1, v2;
        bit          r1, r2;
        logic [3:0]  q1, tag;
        bit          cv;
        logic [3:0]  ct;
        logic [31:0] cd;
        bit          e_empty;
        logic [5:0]  e_op;
        logic [31:0] e_v1, e_v2;
        logic [3:0]  e_tag;
    } vec_t;

    function automatic vec_t row(input bit r, dv, input logic [5:0] op, input logic [31:0] v1, v2,
                                 input bit r1, r2, input logic [3:0] q1, tag,
                                 input bit cv, input logic [3:0] ct, input logic [31:0] cd,
                                 input bit ee, input logic [5:0] eop, input logic [31:0] ev1, ev2,
                                 input logic [3:0] etag);
        vec_t v;
        v.rst = r; v.dv = dv; v.op = op; v.v1 = v1; v.v2 = v2; v.r1 = r1; v.r2 = r2;
        v.q1 = q1; v.tag = tag; v.cv = cv; v.ct = ct; v.cd = cd;
        v.e_empty = ee; v.e_op = eop; v.e_v1 = ev1; v.e_v2 = ev2; v.e_tag = etag;
        return v;
    endfunction

    vec_t tbl[14];

    initial begin
        set_idle();
        //            rst dv op     v1  v2 r1 r2 q1 tag cv ct  cd          ee op     v1         v2 tag
        tbl[0]  = row(1, 0, 6'h00, 0,  0, 0, 0, 0, 0,  0, 0,  0,          1, 6'h00, 0,         0, 0);
        tbl[1]  = row(0, 1, 6'h01, 5,  7, 1, 1, 0, 3,  0, 0,  0,          1, 6'h00, 0,         0, 0);
        tbl[2]  = row(0, 0, 6'h00, 0,  0, 0, 0, 0, 0,  0, 0,  0,          0, 6'h01, 5,         7, 3);
        tbl[3]  = row(0, 0, 6'h00, 0,  0, 0, 0, 0, 0,  0, 0,  0,          1, 6'h00, 0,         0, 0);
        tbl[4]  = row(0, 1, 6'h02, 0,  1, 0, 1, 2, 4,  0, 0,  0,          1, 6'h00, 0,         0, 0);
        tbl[5]  = row(0, 0, 6'h00, 0,  0, 0, 0, 0, 0,  0, 0,  0,          1, 6'h00, 0,         0, 0);
        tbl[6]  = row(0, 0, 6'h00, 0,  0, 0, 0, 0, 0,  0, 0,  0,          1, 6'h00, 0,         0, 0);
        tbl[7]  = row(0, 0, 6'h00, 0,  0, 0, 0, 0, 0,  0, 0,  0,          1, 6'h00, 0,         0, 0);
        tbl[8]  = row(0, 0, 6'h00, 0,  0, 0, 0, 0, 0,  1, 2,  10,         1, 6'h00, 0,         0, 0);
        tbl[9]  = row(0, 0, 6'h00, 0,  0, 0, 0, 0, 0,  0, 0,  0,          0, 6'h02, 10,        1, 4);
        tbl[10] = row(0, 0, 6'h00, 0,  0, 0, 0, 0, 0,  0, 0,  0,          1, 6'h00, 0,         0, 0);
        tbl[11] = row(0, 1, 6'h03, 0,  2, 0, 1, 6, 5,  1, 6,  32'hABCD,   1, 6'h00, 0,         0, 0);
        tbl[12] = row(0, 0, 6'h00, 0,  0, 0, 0, 0, 0,  0, 0,  0,          0, 6'h03, 32'hABCD,  2, 5);
        tbl[13] = row(0, 0, 6'h00, 0,  0, 0, 0, 0, 0,  0, 0,  0,          1, 6'h00, 0,         0, 0);

        for (int i = 0; i < 14; i++) begin
            set_idle();
            rst = tbl[i].rst; disp_valid = tbl[i].dv; disp_op = tbl[i].op;
            disp_v1 = tbl[i].v1; disp_v2 = tbl[i].v2; disp_rdy1 = tbl[i].r1; disp_rdy2 = tbl[i].r2;
            disp_q1 = tbl[i].q1; disp_tag = tbl[i].tag;
            cdb_valid = tbl[i].cv; cdb_tag = tbl[i].ct; cdb_data = tbl[i].cd;
            cycle();
            if (i == 0) chk("reset_full", full, 0);
            chk($sformatf("vec%0d_empty", i), alu_empty, tbl[i].e_empty);
            chk($sformatf("vec%0d_op", i), alu_op, tbl[i].e_op);
            chk($sformatf("vec%0d_v1", i), alu_v1, tbl[i].e_v1);
            chk($sformatf("vec%0d_v2", i), alu_v2, tbl[i].e_v2);
            chk($sformatf("vec%0d_tag", i), alu_tag, tbl[i].e_tag);
        end

        // Full / back-pressure: slot i waits on tag i.
        set_idle(); rst = 1; cycle(); set_idle();
        for (int i = 0; i < 8; i++) begin
            set_disp(6'h04, 0, i, 0, 1, 4'(i), 4'(i));
            chk($sformatf("full_before_disp%0d", i), full, 0);
            cycle();
        end
        set_idle();
        chk("full_after_8", full, 1);
        set_disp(6'h05, 99, 1, 1, 1, 0, 9);
        cycle();
        chk("ninth_no_issue_a", alu_empty, 1);
        set_idle(); cycle();
        chk("ninth_dropped", alu_empty, 1);
        cdb_valid = 1; cdb_tag = 0; cdb_data = 32'h55;
        cycle();
        chk("wake0_no_same_cycle_issue", alu_empty, 1);
        set_idle();
        chk("full_before_issue", full, 1);
        cycle();
        chk("slot0_issue_empty", alu_empty, 0);
        chk("slot0_issue_tag", alu_tag, 0);
        chk("slot0_issue_v1", alu_v1, 32'h55);
        chk("full_after_issue", full, 0);
        set_disp(6'h06, 32'h77, 0, 1, 1, 0, 12);
        cycle();
        chk("refill_full", full, 1);
        set_idle(); cycle();
        chk("refill_issue_tag", alu_tag, 12);
        chk("refill_issue_v1", alu_v1, 32'h77);
        chk("refill_full_after", full, 0);

        // Priority: slots 1 and 4 both wait on tag 9.
        set_idle(); rst = 1; cycle(); set_idle();
        set_disp(6'h07, 0, 0, 0, 1, 10, 0); cycle();
        set_disp(6'h07, 0, 1, 0, 1, 9, 1);  cycle();
        set_disp(6'h07, 0, 2, 0, 1, 11, 2); cycle();
        set_disp(6'h07, 0, 3, 0, 1, 12, 3); cycle();
        set_disp(6'h07, 0, 4, 0, 1, 9, 4);  cycle();
        set_idle(); cdb_valid = 1; cdb_tag = 9; cdb_data = 32'h99;
        cycle();
        chk("prio_wake_empty", alu_empty, 1);
        set_idle(); cycle();
        chk("prio_first_tag", alu_tag, 1);
        chk("prio_first_v1", alu_v1, 32'h99);
        cycle();
        chk("prio_second_tag", alu_tag, 4);
        chk("prio_second_empty", alu_empty, 0);
        cycle();
        chk("prio_done_empty", alu_empty, 1);

        // Flush with five busy slots, a ready dispatch and a CDB hit in the same cycle.
        set_disp(6'h08, 0, 0, 0, 1, 13, 5); cycle();
        set_disp(6'h08, 0, 0, 0, 1, 13, 6); cycle();
        set_idle();
        flush = 1; cdb_valid = 1; cdb_tag = 10; cdb_data = 32'h1234;
        set_disp(6'h09, 1, 2, 1, 1, 0, 7);
        cycle();
        chk("flush_full", full, 0);
        chk("flush_empty", alu_empty, 1);
        for (int k = 0; k < 16; k++) begin
            set_idle(); cdb_valid = 1; cdb_tag = 4'(k); cdb_data = 32'(k);
            cycle();
            chk($sformatf("post_flush_quiet%0d", k), alu_empty, 1);
        end
        set_idle();
        chk("post_flush_full", full, 0);

        // Randomized run against the model (model has tracked every cycle so far).
        chk_model = 1'b1;
        set_idle(); rst = 1; cycle();
        for (int n = 0; n < 3000; n++) begin
            set_idle();
            rst        = ($urandom_range(0, 199) == 0);
            flush      = ($urandom_range(0, 63) == 0);
            disp_valid = ($urandom_range(0, 9) < 6);
            disp_op    = 6'($urandom);
            disp_v1    = $urandom; disp_v2 = $urandom;
            disp_rdy1  = $urandom_range(0, 1); disp_rdy2 = $urandom_range(0, 1);
            disp_q1    = 4'($urandom_range(0, 7)); disp_q2 = 4'($urandom_range(0, 7));
            disp_imm   = $urandom; disp_pc = $urandom; disp_tag = 4'($urandom);
            cdb_valid  = $urandom_range(0, 1);
            cdb_tag    = 4'($urandom_range(0, 7));
            cdb_data   = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
